uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART receiver.
//  - Captures each completed frame (rx_out + frame error) on the receiver's rx_done.
//  - Stores frames in a DEPTH-entry show-ahead FIFO.
//  - Presents frames to the host through a valid/ready interface.
//  - Reports fill level, almost-full and a sticky overflow flag.
// PARAMETERS
//  DEPTH     16  number of entries; power of 2, >= 4
//  AFULL_LVL 12  afull asserts when count >= AFULL_LVL (1..DEPTH)
// PORTS
//  rx_clk     in   1                  receiver clock; all logic on its rising edge
//  rst_n      in   1                  asynchronous, active-low reset
//  rx_done    in   1                  frame-complete strobe from the receiver
//  rx_out     in   8                  received data; valid while rx_done=1
//  rx_error   in   1                  parity/stop error pulse from the receiver
//  out_valid  out  1                  head entry available
//  out_ready  in   1                  host accepts head entry
//  out_data   out  8                  head entry data
//  out_err    out  1                  head entry error flag
//  count      out  $clog2(DEPTH)+1    current number of stored entries
//  afull      out  1                  count >= AFULL_LVL
//  full       out  1                  count == DEPTH
//  overflow   out  1                  sticky: a frame was dropped
//  ovf_clr    in   1                  clears overflow
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//  - wr_ptr, rd_ptr, count, err_pend, done_q, overflow = 0.
//  - Hence out_valid = 0, full = 0, afull = 0.
//  - The memory array is not reset.
//  - A reset mid-frame discards err_pend and all stored entries.
//  Frame capture:
//  - done_q registers rx_done.
//  - push = rx_done & ~done_q (rising edge), so a held strobe pushes once.
//  - err_pend is set on any cycle with rx_error=1 and cleared on the cycle push=1.
//  - A pushed entry stores {err_pend | rx_error, rx_out}.
//  - Reason: the receiver drops rx_error in its done cycle, so the error is
//    accumulated across the frame.
//  Read side (show-ahead):
//  - out_valid = (count != 0).
//  - out_data and out_err come combinationally from mem[rd_ptr].
//  - When out_valid=0, out_data and out_err are don't-care.
//  - pop = out_valid & out_ready. rd_ptr advances on pop.
//  - Latency: a push at edge N gives out_valid=1 after edge N (visible in cycle N+1).
//  Write acceptance:
//  - wr_ok = push & (~full | pop).
//  - On wr_ok: mem[wr_ptr] is written and wr_ptr advances.
//  - A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
//  - Dropped frame (push & full & ~pop): no write, pointers unchanged, overflow <= 1.
//  - In the dropped-frame case, err_pend still clears.
//  Count update:
//  - +1 on wr_ok & ~pop.
//  - -1 on pop & ~wr_ok.
//  - Unchanged when both or neither occur.
//  - Never exceeds DEPTH or goes below 0.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - Empty/full are decided by count, not by pointer compare.
//  overflow:
//  - Set on a drop; cleared by ovf_clr.
//  - If a drop and ovf_clr occur in the same cycle, the set wins.
//  out_ready while empty is ignored; there is no underflow.
//  Status outputs: full and afull are combinational from count.
// TESTING
//  - Reset: rst_n=0 mid-run with 5 entries -> count=0, out_valid=0, overflow=0
//    immediately (async), before the next rx_clk edge.
//  - Single frame: rx_done=1 for 1 cycle with rx_out=8'hA5, rx_error=0 ->
//    next cycle out_valid=1, out_data=8'hA5, out_err=0, count=1.
//    Then out_ready=1 -> count=0.
//  - Error accumulation: rx_error pulses 5 cycles before rx_done (rx_out=8'h3C) ->
//    entry out_err=1.
//    The following clean frame 8'h3D -> out_err=0.
//  - Fill/overflow: 16 frames 8'h00..8'h0F with out_ready=0 -> afull after the
//    12th, full after the 16th.
//    17th frame 8'h10 -> dropped, overflow=1, count=16.
//    Drain all -> data 00..0F in order; ovf_clr -> overflow=0.
//  - Simultaneous: FIFO full with out_ready=1 and a push of 8'h55 in the same cycle ->
//    accepted, count stays 16, overflow stays 0.
//    8'h55 read out 16th.
//  - Held strobe and wrap: rx_done held high 3 cycles -> exactly one push.
//    40 frames streamed with out_ready=1 -> order preserved across pointer wrap,
//    count <= 1 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: captures frames on the rx_done
// rising edge and serves them through a show-ahead valid/ready FIFO.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                       i_rx_clk,
  input  logic                       i_rst_n,
  input  logic                       i_rx_done,
  input  logic [7:0]                 i_rx_out,
  input  logic                       i_rx_error,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [7:0]                 o_out_data,
  output logic                       o_out_err,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_afull,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err_pend;
  logic          r_done_q;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_wr_ok;
  logic          w_drop;
  logic [8:0]    w_head;

  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_push  = i_rx_done & ~r_done_q;
    w_pop   = (r_count != '0) & i_out_ready;
    // A same-cycle pop frees a slot, so a full FIFO can still take the frame.
    w_wr_ok = w_push & (~w_full | w_pop);
    w_drop  = w_push & w_full & ~w_pop;
    w_head  = r_mem[r_rd_ptr];
  end

  always_comb begin
    o_out_valid = (r_count != '0);
    o_out_data  = w_head[7:0];
    o_out_err   = w_head[8];
    o_count     = r_count;
    o_full      = w_full;
    o_afull     = (r_count >= CW'(AFULL_LVL));
    o_overflow  = r_overflow;
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge i_rx_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= {r_err_pend | i_rx_error, i_rx_out};
    end
  end

  always_ff @(posedge i_rx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_err_pend <= 1'b0;
      r_done_q   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q <= i_rx_done;
      // The receiver drops rx_error before rx_done, so errors are held until the push.
      if (w_push) begin
        r_err_pend <= 1'b0;
      end else if (i_rx_error) begin
        r_err_pend <= 1'b1;
      end
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_ok && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_wr_ok) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected frames, a negedge
// monitor compares every accepted head entry in order.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_out;
  logic       rx_error;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [4:0] count;
  logic       afull;
  logic       full;
  logic       overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  uart_rx_fifo #(
    .DEPTH    (16),
    .AFULL_LVL(12)
  ) dut (
    .i_rx_clk   (clk),
    .i_rst_n    (rst_n),
    .i_rx_done  (rx_done),
    .i_rx_out   (rx_out),
    .i_rx_error (rx_error),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_out_err  (out_err),
    .o_count    (count),
    .o_afull    (afull),
    .o_full     (full),
    .o_overflow (overflow),
    .i_ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every head entry the host accepts must match the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none", {out_err, out_data});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({out_err, out_data} !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %0h expected %0h at %0t", {out_err, out_data}, e,
                   $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe rx_done for 'hold' cycles; 'keep' says whether the frame should be stored.
  task automatic send_frame(input logic [7:0] d, input logic err, input int hold,
                            input bit keep);
    if (keep) exp_q.push_back({err, d});
    rx_out  = d;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 40) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk({name, "_drained"}, int'(count), 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_out = 8'h00; rx_error = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(afull), 0);
    chk("rst_ovf", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single frame, visible one cycle after the push edge.
    exp_q.push_back({1'b0, 8'hA5});
    rx_out = 8'hA5; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 'hA5);
    chk("single_err", int'(out_err), 0);
    chk("single_count", int'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", int'(count), 0);
    chk("single_sb_empty", exp_q.size(), 0);

    // Error pulse five cycles ahead of rx_done must stick to that frame only.
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    repeat (4) tick();
    send_frame(8'h3C, 1'b1, 1, 1'b1);
    send_frame(8'h3D, 1'b0, 1, 1'b1);
    chk("err_count", int'(count), 2);
    drain("err");

    // Fill to full, then one dropped frame.
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b0, 1, 1'b1);
      if (i == 10) chk("afull_at_11", int'(afull), 0);
      if (i == 11) chk("afull_at_12", int'(afull), 1);
      if (i == 14) chk("full_at_15", int'(full), 0);
    end
    chk("full_at_16", int'(full), 1);
    chk("count_16", int'(count), 16);
    chk("ovf_before_drop", int'(overflow), 0);
    send_frame(8'h10, 1'b0, 1, 1'b0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), 16);
    drain("fill");
    chk("ovf_sticky", int'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Full FIFO, pop and push on the same edge: frame accepted.
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b0, 1, 1'b1);
    chk("simul_pre_full", int'(full), 1);
    exp_q.push_back({1'b0, 8'h55});
    rx_out = 8'h55; rx_done = 1'b1; out_ready = 1'b1;
    tick();
    rx_done = 1'b0; out_ready = 1'b0;
    chk("simul_count", int'(count), 16);
    chk("simul_ovf", int'(overflow), 0);
    drain("simul");

    // Held strobe pushes once.
    send_frame(8'h77, 1'b0, 3, 1'b1);
    chk("held_count", int'(count), 1);
    drain("held");

    // Stream across several pointer wraps with the host always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_frame(8'(8'h80 + i), 1'b0, 1, 1'b1);
      if (count > 1) chk("wrap_count_le1", int'(count), 1);
    end
    chk("wrap_last_count", int'(count), 0);
    out_ready = 1'b0;
    drain("wrap");

    // Asynchronous reset with five stored entries.
    for (int i = 0; i < 5; i++) send_frame(8'(8'hC0 + i), 1'b0, 1, 1'b1);
    chk("pre_rst_count", int'(count), 5);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ovf", int'(overflow), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h99, 1'b0, 1, 1'b1);
    chk("post_rst_count", int'(count), 1);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
